dco_freq_ctrl: RTL and testbench
================================

DCO_FREQ_CTRL -- requirements
Module: dco_freq_ctrl

Interface
REQ-001 The block SHALL have one clock, clk_i, and an asynchronous, active-low reset, reset_n_i.
REQ-002 Parameter CTRL_WIDTH, 5: width of freq_sel_o; must match the oscillator control width.
REQ-003 Parameter CNT_WIDTH, 16: width of the edge counter and of target_i.
REQ-004 Parameter WINDOW, 1000: length of the measurement window, in clk_i cycles, ≥2.
REQ-005 Parameter SETTLE, 16: number of clk_i cycles discarded after each control change, ≥1.
REQ-006 Parameter TOL, 2: allowed deviation of the edge count from target_i, inclusive.
REQ-007 Parameter LOCK_WINDOWS, 4: number of consecutive in-tolerance windows required to assert lock.
REQ-008 Ports (name, direction, width, meaning):
- clk_i, in, 1: reference clock, ≥4x the DCO frequency.
- reset_n_i, in, 1: asynchronous reset, active-low.
- en_i, in, 1: loop enable.
- target_i, in, CNT_WIDTH: required number of DCO rising edges per window.
- dco_clk_i, in, 1: DCO output, asynchronous to clk_i.
- osc_enable_o, out, 1: oscillator enable.
- osc_reset_o, out, 1: oscillator reset, active-high.
- freq_sel_o, out, CTRL_WIDTH: oscillator tap select; a larger value gives a higher frequency.
- count_o, out, CNT_WIDTH: edge count from the last completed window.
- locked_o, out, 1: frequency lock indication.

Function
REQ-009 dco_clk_i SHALL pass through a two-flop synchronizer; a rising edge is detected by a third flop (sync==1, prev==0).
REQ-010 The FSM SHALL have four states: IDLE, SETTLE, MEASURE, UPDATE.
REQ-011 IDLE: osc_enable_o=0, osc_reset_o=1; when en_i=1, go to SETTLE on the next cycle.
REQ-012 SETTLE: osc_enable_o=1, osc_reset_o=0; stay exactly SETTLE cycles, then go to MEASURE; detected edges are ignored.
REQ-013 MEASURE: stay exactly WINDOW cycles; each cycle with a detected edge increments the counter; the counter saturates at all-ones; the counter clears on MEASURE entry.
REQ-014 UPDATE: lasts one cycle; count_o takes the counter value, and the count is compared with the target_i value sampled in this cycle.
REQ-015 If count < target-TOL, freq_sel_o SHALL increment, saturating at 2^CTRL_WIDTH-1.
REQ-016 If count > target+TOL, freq_sel_o SHALL decrement, saturating at 0.
REQ-017 Otherwise freq_sel_o SHALL be held; the comparison SHALL use CNT_WIDTH+1-bit arithmetic with no wrap-around.
REQ-018 After UPDATE, go to SETTLE if freq_sel_o changed, else go directly to MEASURE.
REQ-019 A new freq_sel_o value SHALL be visible the cycle after UPDATE.
REQ-020 en_i=0 in any state SHALL force IDLE on the next cycle:
- the window is discarded and count_o is not updated;
- freq_sel_o is held;
- locked_o is cleared.
REQ-021 A saturated freq_sel_o SHALL remain unchanged and SHALL NOT trigger SETTLE.

Reset
REQ-022 reset_n_i low SHALL immediately force:
- FSM=IDLE, freq_sel_o=0, count_o=0, locked_o=0;
- osc_enable_o=0, osc_reset_o=1;
- synchronizer, counters and lock counter cleared.
REQ-023 Leaving reset SHALL be synchronous; the first active state (SETTLE) SHALL be no earlier than the second clk_i edge after reset_n_i rises.

Configuration
REQ-024 Macro DCO_FREQ_CTRL_LOCK_DETECT_EN defined: a lock counter counts consecutive in-tolerance UPDATEs, saturating at LOCK_WINDOWS.
- locked_o=1 while the counter equals LOCK_WINDOWS.
- An out-of-tolerance UPDATE clears the counter and locked_o in the same cycle.
REQ-025 Macro undefined: no lock counter is instantiated; locked_o is constant 0; all other behaviour is identical.

Verification
REQ-026 Reset: assert reset_n_i mid-MEASURE -> the same cycle shows freq_sel_o=0, osc_enable_o=0, osc_reset_o=1, locked_o=0.
REQ-027 Slow DCO: WINDOW=100, target=20, DCO 10 edges per window -> freq_sel_o increments 0->1->2..., with SETTLE inserted after each step.
REQ-028 Fast DCO: DCO 30 edges per window, freq_sel starting at 3 -> freq_sel_o decrements toward 0 and stays 0 without further SETTLE.
REQ-029 Lock (macro on): 21 edges per window, target=20, TOL=2 -> freq_sel_o held, locked_o=1 after the 4th UPDATE; then 25 edges -> locked_o=0 in that UPDATE cycle.
REQ-030 Lock (macro off): the same stimulus as REQ-029 -> locked_o stays 0.
REQ-031 Enable drop: deassert en_i at cycle 50 of a window -> IDLE next cycle, count_o unchanged, freq_sel_o unchanged; reassert -> SETTLE, then a full window.

Source files
------------

// File: rtl/dco_freq_ctrl.sv
// Closed-loop DCO frequency controller: counts synchronised DCO edges per window and trims the tap select.
// Optional lock detector is built when DCO_FREQ_CTRL_LOCK_DETECT_EN is defined; otherwise locked_o is tied low.
module dco_freq_ctrl #(
  parameter int CTRL_WIDTH   = 5,
  parameter int CNT_WIDTH    = 16,
  parameter int WINDOW       = 1000,
  parameter int SETTLE       = 16,
  parameter int TOL          = 2,
  parameter int LOCK_WINDOWS = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  en_i,
  input  logic [CNT_WIDTH-1:0]  target_i,
  input  logic                  dco_clk_i,
  output logic                  osc_enable_o,
  output logic                  osc_reset_o,
  output logic [CTRL_WIDTH-1:0] freq_sel_o,
  output logic [CNT_WIDTH-1:0]  count_o,
  output logic                  locked_o
);

  localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TMR_W   = $clog2(TMR_MAX);
  localparam logic [TMR_W-1:0]      SETTLE_LAST = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0]      WINDOW_LAST = TMR_W'(WINDOW - 1);
  localparam logic [CTRL_WIDTH-1:0] SEL_MAX     = {CTRL_WIDTH{1'b1}};
  localparam logic [CTRL_WIDTH-1:0] SEL_MIN     = {CTRL_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX     = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH:0]    TOL_EXT     = (CNT_WIDTH + 1)'(TOL);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_UPDATE  = 2'd3
  } state_t;

  state_t                state_r;
  logic [1:0]            sync_r;
  logic                  prev_r;
  logic                  rst_done_r;
  logic [TMR_W-1:0]      timer_r;
  logic [CNT_WIDTH-1:0]  cnt_r;
  logic [CNT_WIDTH-1:0]  count_r;
  logic [CTRL_WIDTH-1:0] freq_sel_r;
  logic                  osc_enable_r;
  logic                  osc_reset_r;

  logic                  edge_s;
  logic [CNT_WIDTH-1:0]  cnt_next_s;
  logic                  too_slow_s;
  logic                  too_fast_s;
  logic                  can_inc_s;
  logic                  can_dec_s;

  // Two-flop synchroniser for the asynchronous DCO plus a history flop for edge detection
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync_r <= 2'b00;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[0], dco_clk_i};
      prev_r <= sync_r[1];
    end
  end

  // Saturating edge count and tolerance decision; the extra MSB keeps target +/- TOL from wrapping
  always_comb begin
    edge_s     = sync_r[1] & ~prev_r;
    cnt_next_s = cnt_r;
    if (edge_s && (cnt_r != CNT_MAX)) begin
      cnt_next_s = cnt_r + CNT_WIDTH'(1);
    end else begin
      cnt_next_s = cnt_r;
    end
    too_slow_s = (({1'b0, cnt_r} + TOL_EXT) < {1'b0, target_i});
    too_fast_s = ({1'b0, cnt_r} > ({1'b0, target_i} + TOL_EXT));
    can_inc_s  = too_slow_s && (freq_sel_r != SEL_MAX);
    can_dec_s  = too_fast_s && (freq_sel_r != SEL_MIN);
  end

  // Control FSM; rst_done_r holds the loop in IDLE for the first clock after reset release
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r      <= ST_IDLE;
      rst_done_r   <= 1'b0;
      timer_r      <= {TMR_W{1'b0}};
      cnt_r        <= {CNT_WIDTH{1'b0}};
      count_r      <= {CNT_WIDTH{1'b0}};
      freq_sel_r   <= SEL_MIN;
      osc_enable_r <= 1'b0;
      osc_reset_r  <= 1'b1;
    end else begin
      rst_done_r <= 1'b1;
      if (!en_i) begin
        state_r      <= ST_IDLE;
        osc_enable_r <= 1'b0;
        osc_reset_r  <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (rst_done_r) begin
              state_r      <= ST_SETTLE;
              timer_r      <= {TMR_W{1'b0}};
              osc_enable_r <= 1'b1;
              osc_reset_r  <= 1'b0;
            end
          end
          ST_SETTLE: begin
            if (timer_r == SETTLE_LAST) begin
              state_r <= ST_MEASURE;
              timer_r <= {TMR_W{1'b0}};
              cnt_r   <= {CNT_WIDTH{1'b0}};
            end else begin
              timer_r <= timer_r + TMR_W'(1);
            end
          end
          ST_MEASURE: begin
            cnt_r <= cnt_next_s;
            if (timer_r == WINDOW_LAST) begin
              state_r <= ST_UPDATE;
            end else begin
              timer_r <= timer_r + TMR_W'(1);
            end
          end
          ST_UPDATE: begin
            count_r <= cnt_r;
            timer_r <= {TMR_W{1'b0}};
            // A saturated select counts as "held" and goes straight back to measuring
            if (can_inc_s) begin
              freq_sel_r <= freq_sel_r + CTRL_WIDTH'(1);
              state_r    <= ST_SETTLE;
            end else if (can_dec_s) begin
              freq_sel_r <= freq_sel_r - CTRL_WIDTH'(1);
              state_r    <= ST_SETTLE;
            end else begin
              state_r <= ST_MEASURE;
              cnt_r   <= {CNT_WIDTH{1'b0}};
            end
          end
          default: begin
            state_r      <= ST_IDLE;
            osc_enable_r <= 1'b0;
            osc_reset_r  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign osc_enable_o = osc_enable_r;
  assign osc_reset_o  = osc_reset_r;
  assign freq_sel_o   = freq_sel_r;
  assign count_o      = count_r;

`ifdef DCO_FREQ_CTRL_LOCK_DETECT_EN
  localparam int LOCK_W = $clog2(LOCK_WINDOWS + 1);
  localparam logic [LOCK_W-1:0] LOCK_FULL = LOCK_W'(LOCK_WINDOWS);

  logic [LOCK_W-1:0] lock_cnt_r;
  logic              update_s;
  logic              in_tol_s;

  // An update is only real while the loop is still enabled
  always_comb begin
    update_s = (state_r == ST_UPDATE) && en_i;
    in_tol_s = !too_slow_s && !too_fast_s;
  end

  // Consecutive in-tolerance update counter, saturating at LOCK_WINDOWS
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lock_cnt_r <= {LOCK_W{1'b0}};
    end else if (!en_i) begin
      lock_cnt_r <= {LOCK_W{1'b0}};
    end else if (update_s) begin
      if (!in_tol_s) begin
        lock_cnt_r <= {LOCK_W{1'b0}};
      end else if (lock_cnt_r != LOCK_FULL) begin
        lock_cnt_r <= lock_cnt_r + LOCK_W'(1);
      end
    end
  end

  // The out-of-tolerance mask drops lock during the offending update cycle itself
  assign locked_o = (lock_cnt_r == LOCK_FULL) && !(update_s && !in_tol_s);
`else
  assign locked_o = 1'b0;
`endif

endmodule

// File: tb/tb_dco_freq_ctrl.sv
// Self-checking bench for dco_freq_ctrl: a cycle-level scoreboard plus scenario-specific checks.
module tb_dco_freq_ctrl;

  localparam int CW   = 5;
  localparam int NW   = 16;
  localparam int WIN  = 100;
  localparam int STL  = 16;
  localparam int TOLP = 2;
  localparam int LW   = 4;
  localparam int FMAX = (1 << CW) - 1;
`ifdef DCO_FREQ_CTRL_LOCK_DETECT_EN
  localparam logic LOCK_ON = 1'b1;
`else
  localparam logic LOCK_ON = 1'b0;
`endif

  typedef logic [NW+CW+2:0] obs_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          en;
  logic [NW-1:0] target;
  logic          dco;
  logic          osc_enable_o;
  logic          osc_reset_o;
  logic [CW-1:0] freq_sel_o;
  logic [NW-1:0] count_o;
  logic          locked_o;

  int   tests = 0;
  int   fails = 0;
  int   rate  = 10;
  int   acc   = 0;
  obs_t exp_q[$];
  obs_t exp_v;

  // reference model state
  int   m_phase;
  int   m_left;
  int   m_freq;
  int   m_count;
  int   m_lock;
  bit   m_ready;

  dco_freq_ctrl #(
    .CTRL_WIDTH(CW), .CNT_WIDTH(NW), .WINDOW(WIN), .SETTLE(STL), .TOL(TOLP), .LOCK_WINDOWS(LW)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .en_i(en), .target_i(target), .dco_clk_i(dco),
    .osc_enable_o(osc_enable_o), .osc_reset_o(osc_reset_o), .freq_sel_o(freq_sel_o),
    .count_o(count_o), .locked_o(locked_o)
  );

  initial forever #5 clk = ~clk;

  // phase accumulator: exactly 'rate' rising edges in any WIN consecutive clocks
  initial begin
    dco = 1'b0;
    forever begin
      @(negedge clk);
      acc = acc + 2 * rate;
      if (acc >= WIN) begin
        acc = acc - WIN;
        dco = ~dco;
      end
    end
  end

  function automatic obs_t observe();
    return {osc_enable_o, osc_reset_o, locked_o, freq_sel_o, count_o};
  endfunction

  function automatic bit out_of_tol(int n, int t);
    return ((n + TOLP) < t) || (n > (t + TOLP));
  endfunction

  function automatic obs_t model_out();
    logic e, r, l;
    int   t;
    t = target;
    e = (m_phase != 0);
    r = (m_phase == 0);
    l = LOCK_ON && (m_lock == LW) && !((m_phase == 3) && en && out_of_tol(rate, t));
    return {e, r, l, CW'(m_freq), NW'(m_count)};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_freq = 0; m_count = 0; m_lock = 0; m_ready = 1'b0;
    exp_q.delete();
  endtask

  // one clock: advance the model, queue its prediction, then let the DUT take the edge
  task automatic tick();
    bit was_ready;
    int t;
    t = target;
    was_ready = m_ready;
    m_ready = 1'b1;
    if (!en) begin
      m_phase = 0;
      m_lock  = 0;
    end else begin
      case (m_phase)
        0: if (was_ready) begin m_phase = 1; m_left = STL; end
        1: begin m_left--; if (m_left == 0) begin m_phase = 2; m_left = WIN; end end
        2: begin m_left--; if (m_left == 0) m_phase = 3; end
        default: begin
          m_count = rate;
          if (((rate + TOLP) < t) && (m_freq < FMAX)) begin
            m_freq++; m_phase = 1; m_left = STL;
          end else if ((rate > (t + TOLP)) && (m_freq > 0)) begin
            m_freq--; m_phase = 1; m_left = STL;
          end else begin
            m_phase = 2; m_left = WIN;
          end
          if (out_of_tol(rate, t)) m_lock = 0;
          else if (m_lock < LW) m_lock++;
        end
      endcase
    end
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    en = 1'b0; target = 16'd20; rate = 10; reset_n = 1'b0;
    model_reset();
    #12;
    tests++;
    if (observe() !== {1'b0, 1'b1, 1'b0, 5'd0, 16'd0}) begin
      fails++; $display("FAIL reset_state: dut=%h exp=%h", observe(), {1'b0, 1'b1, 1'b0, 5'd0, 16'd0});
    end
    @(posedge clk); #1;
    reset_n = 1'b1; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); exp_v = exp_q.pop_front(); tests++;
      if (observe() !== exp_v) begin
        fails++; $display("FAIL reset_release cyc%0d: dut=%h exp=%h", i, observe(), exp_v);
      end
    end
  endtask

  task automatic test_slow();
    int last_chg = -1;
    logic [CW-1:0] prev = freq_sel_o;
    for (int i = 0; i < 1000 && freq_sel_o != 5'd3; i++) begin
      tick(); exp_v = exp_q.pop_front(); tests++;
      if (observe() !== exp_v) begin
        fails++; $display("FAIL slow_cycle: dut=%h exp=%h", observe(), exp_v);
      end
      if (freq_sel_o != prev) begin
        tests++;
        if (freq_sel_o !== prev + 5'd1) begin
          fails++; $display("FAIL slow_step: freq=%0d exp=%0d", freq_sel_o, prev + 5'd1);
        end
        if (last_chg >= 0) begin
          tests++;
          if (i - last_chg != STL + WIN + 1) begin
            fails++; $display("FAIL slow_interval: got=%0d exp=%0d", i - last_chg, STL + WIN + 1);
          end
        end
        last_chg = i; prev = freq_sel_o;
      end
    end
    tests++;
    if (freq_sel_o !== 5'd3) begin
      fails++; $display("FAIL slow_timeout: freq=%0d exp=3", freq_sel_o);
    end
    en = 1'b0;
    tick(); exp_v = exp_q.pop_front(); tests++;
    if (observe() !== exp_v) begin
      fails++; $display("FAIL slow_disable: dut=%h exp=%h", observe(), exp_v);
    end
  endtask

  task automatic test_fast();
    logic [CW-1:0] prev = freq_sel_o;
    rate = 30; target = 16'd20; en = 1'b1;
    for (int i = 0; i < 1000 && freq_sel_o != 5'd0; i++) begin
      tick(); exp_v = exp_q.pop_front(); tests++;
      if (observe() !== exp_v) begin
        fails++; $display("FAIL fast_cycle: dut=%h exp=%h", observe(), exp_v);
      end
      if (freq_sel_o != prev) begin
        tests++;
        if (freq_sel_o !== prev - 5'd1) begin
          fails++; $display("FAIL fast_step: freq=%0d exp=%0d", freq_sel_o, prev - 5'd1);
        end
        prev = freq_sel_o;
      end
    end
    for (int i = 0; i < 2 * (WIN + 1) + 5; i++) begin
      tick(); exp_v = exp_q.pop_front(); tests++;
      if (observe() !== exp_v || freq_sel_o !== 5'd0) begin
        fails++; $display("FAIL fast_hold0: dut=%h exp=%h", observe(), exp_v);
      end
    end
    // a retarget exposes whether a SETTLE was wrongly inserted at the floor
    target = 16'd40;
    for (int i = 0; i < 300 && freq_sel_o != 5'd1; i++) begin
      tick(); exp_v = exp_q.pop_front(); tests++;
      if (observe() !== exp_v) begin
        fails++; $display("FAIL fast_retarget: dut=%h exp=%h", observe(), exp_v);
      end
    end
    en = 1'b0;
    tick(); exp_v = exp_q.pop_front(); tests++;
    if (observe() !== exp_v) begin
      fails++; $display("FAIL fast_disable: dut=%h exp=%h", observe(), exp_v);
    end
  endtask

  task automatic test_tolerance();
    int tbl_rate[6] = '{18, 22, 17, 23, 1, 10};
    int tbl_tgt[6]  = '{20, 20, 20, 20, 0, 65535};
    int tbl_frq[6]  = '{1, 1, 2, 1, 1, 2};
    for (int k = 0; k < 6; k++) begin
      rate = tbl_rate[k]; target = NW'(tbl_tgt[k]); en = 1'b1;
      for (int i = 0; i < STL + WIN + 2; i++) begin
        tick(); exp_v = exp_q.pop_front(); tests++;
        if (observe() !== exp_v) begin
          fails++; $display("FAIL tol_cycle case%0d: dut=%h exp=%h", k, observe(), exp_v);
        end
      end
      tests++;
      if (freq_sel_o !== CW'(tbl_frq[k]) || count_o !== NW'(tbl_rate[k])) begin
        fails++; $display("FAIL tol_result case%0d: freq=%0d cnt=%0d exp freq=%0d cnt=%0d",
                          k, freq_sel_o, count_o, tbl_frq[k], tbl_rate[k]);
      end
      en = 1'b0;
      tick(); exp_v = exp_q.pop_front(); tests++;
      if (observe() !== exp_v) begin
        fails++; $display("FAIL tol_disable case%0d: dut=%h exp=%h", k, observe(), exp_v);
      end
    end
  endtask

  task automatic test_lock();
    int chg = -1, fall = -1, exp_fall;
    logic prev_lock;
    rate = 21; target = 16'd20; en = 1'b1;
    for (int i = 1; i <= 1 + STL + 4 * (WIN + 1); i++) begin
      tick(); exp_v = exp_q.pop_front(); tests++;
      if (observe() !== exp_v) begin
        fails++; $display("FAIL lock_cycle: dut=%h exp=%h", observe(), exp_v);
      end
      if (i == 1 + STL + 3 * (WIN + 1)) begin
        tests++;
        if (locked_o !== 1'b0) begin
          fails++; $display("FAIL lock_early: locked=%b exp=0", locked_o);
        end
      end
    end
    tests++;
    if (locked_o !== LOCK_ON || freq_sel_o !== 5'd2) begin
      fails++; $display("FAIL lock_after4: locked=%b freq=%0d exp locked=%b freq=2", locked_o, freq_sel_o, LOCK_ON);
    end
    target = 16'd16;
    prev_lock = locked_o;
    for (int i = 0; i < 300 && chg < 0; i++) begin
      tick(); exp_v = exp_q.pop_front(); tests++;
      if (observe() !== exp_v) begin
        fails++; $display("FAIL unlock_cycle: dut=%h exp=%h", observe(), exp_v);
      end
      if (prev_lock && !locked_o) fall = i;
      if (freq_sel_o != 5'd2) chg = i;
      prev_lock = locked_o;
    end
    exp_fall = LOCK_ON ? chg - 1 : -1;
    tests++;
    if (chg < 0 || fall != exp_fall) begin
      fails++; $display("FAIL unlock_timing: fall=%0d chg=%0d exp fall=%0d", fall, chg, exp_fall);
    end
    en = 1'b0;
    tick(); exp_v = exp_q.pop_front(); tests++;
    if (observe() !== exp_v) begin
      fails++; $display("FAIL lock_disable: dut=%h exp=%h", observe(), exp_v);
    end
  endtask

  task automatic test_enable_drop();
    rate = 21; target = 16'd20; en = 1'b1;
    for (int i = 0; i < STL + WIN + 2 + 50; i++) begin
      tick(); exp_v = exp_q.pop_front(); tests++;
      if (observe() !== exp_v) begin
        fails++; $display("FAIL endrop_cycle: dut=%h exp=%h", observe(), exp_v);
      end
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); exp_v = exp_q.pop_front(); tests++;
      if (observe() !== exp_v || osc_enable_o !== 1'b0 || count_o !== 16'd21 || freq_sel_o !== 5'd1) begin
        fails++; $display("FAIL endrop_idle: dut=%h exp=%h", observe(), exp_v);
      end
    end
    rate = 19; en = 1'b1;
    for (int i = 1; i <= STL + WIN + 2; i++) begin
      tick(); exp_v = exp_q.pop_front(); tests++;
      if (observe() !== exp_v) begin
        fails++; $display("FAIL endrop_resume: dut=%h exp=%h", observe(), exp_v);
      end
      if (i == STL + WIN + 1) begin
        tests++;
        if (count_o !== 16'd21) begin
          fails++; $display("FAIL endrop_early: cnt=%0d exp=21", count_o);
        end
      end
    end
    tests++;
    if (count_o !== 16'd19 || freq_sel_o !== 5'd1) begin
      fails++; $display("FAIL endrop_window: cnt=%0d freq=%0d exp cnt=19 freq=1", count_o, freq_sel_o);
    end
    en = 1'b0;
    tick(); exp_v = exp_q.pop_front(); tests++;
    if (observe() !== exp_v) begin
      fails++; $display("FAIL endrop_disable: dut=%h exp=%h", observe(), exp_v);
    end
  endtask

  task automatic test_saturate_top();
    rate = 10; target = 16'd20; en = 1'b1;
    for (int i = 0; i < 4000 && freq_sel_o != 5'd31; i++) begin
      tick(); exp_v = exp_q.pop_front(); tests++;
      if (observe() !== exp_v) begin
        fails++; $display("FAIL top_climb: dut=%h exp=%h", observe(), exp_v);
      end
    end
    for (int i = 0; i < 2 * (WIN + 1); i++) begin
      tick(); exp_v = exp_q.pop_front(); tests++;
      if (observe() !== exp_v || freq_sel_o !== 5'd31) begin
        fails++; $display("FAIL top_hold: dut=%h exp=%h", observe(), exp_v);
      end
    end
    target = 16'd5;
    for (int i = 0; i < 300 && freq_sel_o != 5'd30; i++) begin
      tick(); exp_v = exp_q.pop_front(); tests++;
      if (observe() !== exp_v) begin
        fails++; $display("FAIL top_retarget: dut=%h exp=%h", observe(), exp_v);
      end
    end
    tests++;
    if (freq_sel_o !== 5'd30) begin
      fails++; $display("FAIL top_timeout: freq=%0d exp=30", freq_sel_o);
    end
    en = 1'b0;
    tick(); exp_v = exp_q.pop_front(); tests++;
    if (observe() !== exp_v) begin
      fails++; $display("FAIL top_disable: dut=%h exp=%h", observe(), exp_v);
    end
  endtask

  task automatic test_reset_mid_measure();
    rate = 10; target = 16'd10; en = 1'b1;
    for (int i = 0; i < 1 + STL + 4 * (WIN + 1) + 50; i++) begin
      tick(); exp_v = exp_q.pop_front(); tests++;
      if (observe() !== exp_v) begin
        fails++; $display("FAIL rstmid_cycle: dut=%h exp=%h", observe(), exp_v);
      end
    end
    tests++;
    if (locked_o !== LOCK_ON || freq_sel_o !== 5'd30) begin
      fails++; $display("FAIL rstmid_pre: locked=%b freq=%0d exp locked=%b freq=30", locked_o, freq_sel_o, LOCK_ON);
    end
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (observe() !== {1'b0, 1'b1, 1'b0, 5'd0, 16'd0}) begin
      fails++; $display("FAIL rstmid_async: dut=%h exp=%h", observe(), {1'b0, 1'b1, 1'b0, 5'd0, 16'd0});
    end
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(); exp_v = exp_q.pop_front(); tests++;
      if (observe() !== exp_v) begin
        fails++; $display("FAIL rstmid_restart: dut=%h exp=%h", observe(), exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_slow();
    test_fast();
    test_tolerance();
    test_lock();
    test_enable_drop();
    test_saturate_top();
    test_reset_mid_measure();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
